// File: rtl/qnm_cam.sv
// qnm_cam: circular FIFO of {N,M} entries with per-slot valid bits, occupancy
// count, in-place M-field update and associative N-field match. Used in the
// cache miss path to track outstanding requests (N = line address, M = status).
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   wr, n_din, m_din push request and entry fields
//   rd               pop request
//   dout             head entry {N,M}; zero when empty
//   full, empty      occupancy flags
//   count            current occupancy
//   modify_vector    per-slot M-field update enable (gated by valid)
//   new_m_vector     replacement M-fields, slot k at [k*M_WIDTH +: M_WIDTH]
//   old_m_vector     current M-field of every slot, same packing
//   valid_vector     per-slot valid bits
//   search_n         associative lookup key
//   match_vector     valid & (N-field == search_n), per slot
//   overflow         one-cycle pulse after a dropped push
//   underflow        one-cycle pulse after an ignored pop
module qnm_cam #(
  parameter int unsigned N_WIDTH  = 8,
  parameter int unsigned M_WIDTH  = 8,
  parameter int unsigned Q_LENGTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr,
  input  logic [N_WIDTH-1:0]            n_din,
  input  logic [M_WIDTH-1:0]            m_din,
  input  logic                          rd,
  output logic [N_WIDTH+M_WIDTH-1:0]    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(Q_LENGTH+1)-1:0] count,
  input  logic [Q_LENGTH-1:0]           modify_vector,
  input  logic [M_WIDTH*Q_LENGTH-1:0]   new_m_vector,
  output logic [M_WIDTH*Q_LENGTH-1:0]   old_m_vector,
  output logic [Q_LENGTH-1:0]           valid_vector,
  input  logic [N_WIDTH-1:0]            search_n,
  output logic [Q_LENGTH-1:0]           match_vector,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned PTR_W = $clog2(Q_LENGTH);
  localparam int unsigned CNT_W = $clog2(Q_LENGTH + 1);

  logic [N_WIDTH-1:0]  r_n     [Q_LENGTH];
  logic [M_WIDTH-1:0]  r_m     [Q_LENGTH];
  logic [Q_LENGTH-1:0] r_valid;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(Q_LENGTH));
  assign w_empty = (r_count == '0);
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push  = wr & (~w_full | rd);
  assign w_pop   = rd & ~w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int k = 0; k < Q_LENGTH; k++) begin
        r_n[k] <= '0;
        r_m[k] <= '0;
      end
    end else begin
      for (int k = 0; k < Q_LENGTH; k++) begin
        if (modify_vector[k] && r_valid[k]) begin
          r_m[k] <= new_m_vector[k*M_WIDTH +: M_WIDTH];
        end
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr <= (r_rd_ptr == PTR_W'(Q_LENGTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      // Push comes after modify and pop so that push data and valid win on a
      // shared slot.
      if (w_push) begin
        r_n[r_wr_ptr]     <= n_din;
        r_m[r_wr_ptr]     <= m_din;
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(Q_LENGTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= wr & w_full & ~rd;
      r_underflow <= rd & w_empty;
    end
  end

  always_comb begin
    old_m_vector = '0;
    match_vector = '0;
    for (int k = 0; k < Q_LENGTH; k++) begin
      old_m_vector[k*M_WIDTH +: M_WIDTH] = r_m[k];
      match_vector[k] = r_valid[k] & (r_n[k] == search_n);
    end
  end

  assign dout         = w_empty ? '0 : {r_n[r_rd_ptr], r_m[r_rd_ptr]};
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign valid_vector = r_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_qnm_cam.sv
// Directed testbench for qnm_cam with a 6-entry queue (non-power-of-two wrap).
module tb_qnm_cam;

  localparam int unsigned NW = 8;
  localparam int unsigned MW = 8;
  localparam int unsigned QL = 6;
  localparam int unsigned CW = $clog2(QL + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             wr;
  logic [NW-1:0]    n_din;
  logic [MW-1:0]    m_din;
  logic             rd;
  logic [NW+MW-1:0] dout;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic [QL-1:0]    modify_vector;
  logic [MW*QL-1:0] new_m_vector;
  logic [MW*QL-1:0] old_m_vector;
  logic [QL-1:0]    valid_vector;
  logic [NW-1:0]    search_n;
  logic [QL-1:0]    match_vector;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_pass   = 0;

  qnm_cam #(
    .N_WIDTH  (NW),
    .M_WIDTH  (MW),
    .Q_LENGTH (QL)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr),
    .n_din         (n_din),
    .m_din         (m_din),
    .rd            (rd),
    .dout          (dout),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .modify_vector (modify_vector),
    .new_m_vector  (new_m_vector),
    .old_m_vector  (old_m_vector),
    .valid_vector  (valid_vector),
    .search_n      (search_n),
    .match_vector  (match_vector),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] n, input logic [7:0] m);
    wr = 1'b1; n_din = n; m_din = m;
    step();
    wr = 1'b0;
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr = 1'b0; rd = 1'b0; n_din = '0; m_din = '0;
    modify_vector = '0; new_m_vector = '0; search_n = '0;

    // Reset state
    do_reset();
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_valid", valid_vector, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_udf", underflow, 0);

    // Basic push/pop
    push(8'h11, 8'hA1);
    push(8'h22, 8'hB2);
    check_eq("pp_count", count, 2);
    check_eq("pp_valid", valid_vector, 6'h03);
    check_eq("pp_dout", dout, 16'h11A1);
    pop();
    check_eq("pop_dout", dout, 16'h22B2);
    check_eq("pop_count", count, 1);
    check_eq("pop_valid", valid_vector, 6'h02);

    // Associative match with duplicate keys
    do_reset();
    push(8'h40, 8'h00);
    push(8'h41, 8'h01);
    push(8'h40, 8'h02);
    search_n = 8'h40;
    #1;
    check_eq("match_40", match_vector, 6'h05);
    search_n = 8'h41;
    #1;
    check_eq("match_41", match_vector, 6'h02);
    search_n = 8'h40;
    pop();
    check_eq("match_after_pop", match_vector, 6'h04);

    // Modify gated by valid
    do_reset();
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    modify_vector = 6'h07;
    new_m_vector = '0;
    new_m_vector[0*MW +: MW] = 8'hC0;
    new_m_vector[1*MW +: MW] = 8'hC1;
    new_m_vector[2*MW +: MW] = 8'hC2;
    step();
    modify_vector = '0;
    check_eq("mod_slot0", old_m_vector[0*MW +: MW], 8'hC0);
    check_eq("mod_slot1", old_m_vector[1*MW +: MW], 8'hC1);
    check_eq("mod_slot2_inv", old_m_vector[2*MW +: MW], 8'h00);
    check_eq("mod_dout", dout, 16'h01C0);
    // Modify slot 2 while pushing into it
    modify_vector = 6'h04;
    new_m_vector[2*MW +: MW] = 8'hEE;
    push(8'h03, 8'h33);
    modify_vector = '0;
    check_eq("mod_push_slot2", old_m_vector[2*MW +: MW], 8'h33);
    check_eq("mod_push_valid", valid_vector, 6'h07);
    // Modify the head while popping it: pop completes, slot ends invalid
    modify_vector = 6'h01;
    new_m_vector[0*MW +: MW] = 8'hDD;
    pop();
    modify_vector = '0;
    check_eq("mod_pop_valid", valid_vector, 6'h06);
    check_eq("mod_pop_dout", dout, 16'h02C1);
    check_eq("mod_pop_count", count, 2);

    // Fill, overflow, push+pop while full with wrap
    do_reset();
    for (int i = 0; i < QL; i++) push(8'h50 + 8'(i), 8'(i));
    check_eq("fill_full", full, 1);
    check_eq("fill_count", count, QL);
    check_eq("fill_valid", valid_vector, 6'h3F);
    push(8'h99, 8'h99);
    check_eq("ovf_pulse", overflow, 1);
    check_eq("ovf_count", count, QL);
    check_eq("ovf_dout", dout, 16'h5000);
    step();
    check_eq("ovf_clear", overflow, 0);
    // Both pointers at slot 0; also modify slot 0 to confirm push data wins
    modify_vector = 6'h01;
    new_m_vector[0*MW +: MW] = 8'hEE;
    wr = 1'b1; rd = 1'b1; n_din = 8'h77; m_din = 8'h77;
    step();
    wr = 1'b0; rd = 1'b0; modify_vector = '0;
    check_eq("fp_count", count, QL);
    check_eq("fp_full", full, 1);
    check_eq("fp_ovf", overflow, 0);
    check_eq("fp_dout", dout, 16'h5101);
    check_eq("fp_slot0_m", old_m_vector[0*MW +: MW], 8'h77);
    check_eq("fp_valid", valid_vector, 6'h3F);
    for (int i = 1; i < QL; i++) begin
      check_eq("drain_dout", dout, {8'h50 + 8'(i), 8'(i)});
      pop();
    end
    check_eq("wrap_dout", dout, 16'h7777);
    check_eq("wrap_count", count, 1);

    // Underflow
    do_reset();
    pop();
    check_eq("udf_pulse", underflow, 1);
    check_eq("udf_count", count, 0);
    step();
    check_eq("udf_clear", underflow, 0);
    wr = 1'b1; rd = 1'b1; n_din = 8'h12; m_din = 8'h34;
    step();
    wr = 1'b0; rd = 1'b0;
    check_eq("ep_count", count, 1);
    check_eq("ep_dout", dout, 16'h1234);
    check_eq("ep_udf", underflow, 1);
    check_eq("ep_empty", empty, 0);

    // Reset overrides wr/rd while full
    do_reset();
    for (int i = 0; i < QL; i++) push(8'hA0 + 8'(i), 8'hF0 + 8'(i));
    check_eq("pre_rst_full", full, 1);
    wr = 1'b1; rd = 1'b1; rst = 1'b1;
    step();
    wr = 1'b0; rd = 1'b0; rst = 1'b0;
    check_eq("mr_count", count, 0);
    check_eq("mr_empty", empty, 1);
    check_eq("mr_valid", valid_vector, 0);
    check_eq("mr_ovf", overflow, 0);
    check_eq("mr_udf", underflow, 0);
    check_eq("mr_dout", dout, 0);
    check_eq("mr_old_m", old_m_vector, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
